// File: rtl/ahb_mmio_pkg.sv
// Shared AHB-Lite encodings and the data-phase state type for the MMIO decoder.
package ahb_mmio_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SLV,
        ST_ERR1,
        ST_ERR2
    } state_e;

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: sequences the two-cycle AHB ERROR response for unmapped,
// quarantined or timed-out transfers.
module ahb_default_slave
    import ahb_mmio_pkg::*;
(
    input  logic HCLK,
    input  logic HRESET,
    input  logic i_start,
    output logic o_hreadyout,
    output logic o_hresp
);

    state_e r_state;
    logic   r_hreadyout;
    logic   r_hresp;

    // ERR1 is never interrupted: HREADYOUT is low, so no new address phase can land.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state     <= ST_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= HRESP_OKAY;
        end else if (r_state == ST_ERR1) begin
            r_state     <= ST_ERR2;
            r_hreadyout <= 1'b1;
            r_hresp     <= HRESP_ERROR;
        end else if (i_start) begin
            r_state     <= ST_ERR1;
            r_hreadyout <= 1'b0;
            r_hresp     <= HRESP_ERROR;
        end else begin
            r_state     <= ST_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= HRESP_OKAY;
        end
    end

    assign o_hreadyout = r_hreadyout;
    assign o_hresp     = r_hresp;

endmodule

// File: rtl/ahb_mmio_decoder.sv
// AHB-Lite single-master to N-slave decoder with response mux, default ERROR
// slave and a per-transfer hang watchdog that quarantines stuck slots.
module ahb_mmio_decoder
    import ahb_mmio_pkg::*;
#(
    parameter int                    NUM_SLAVES     = 4,
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    SLOT_SHIFT     = 12,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 32'h7000_0000,
    parameter int                    TIMEOUT_CYCLES = 1024
) (
    input  logic                             HCLK,
    input  logic                             HRESET,
    input  logic                             HSEL_M,
    input  logic [ADDR_WIDTH-1:0]            HADDR_M,
    input  logic [1:0]                       HTRANS_M,
    input  logic                             HWRITE_M,
    input  logic [2:0]                       HSIZE_M,
    input  logic [2:0]                       HBURST_M,
    input  logic [3:0]                       HPROT_M,
    input  logic [DATA_WIDTH-1:0]            HWDATA_M,
    input  logic                             HREADY_M,
    output logic [DATA_WIDTH-1:0]            HRDATA_M,
    output logic                             HREADYOUT_M,
    output logic                             HRESP_M,
    output logic [NUM_SLAVES-1:0]            HSEL_S,
    output logic [ADDR_WIDTH-1:0]            HADDR_S,
    output logic [1:0]                       HTRANS_S,
    output logic                             HWRITE_S,
    output logic [2:0]                       HSIZE_S,
    output logic [2:0]                       HBURST_S,
    output logic [3:0]                       HPROT_S,
    output logic [DATA_WIDTH-1:0]            HWDATA_S,
    output logic                             HREADY_S,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] HRDATA_S,
    input  logic [NUM_SLAVES-1:0]            HREADYOUT_S,
    input  logic [NUM_SLAVES-1:0]            HRESP_S,
    input  logic                             QUAR_CLR,
    output logic [NUM_SLAVES-1:0]            QUARANTINE,
    output logic                             TIMEOUT_IRQ
);

    localparam int IDXW = (NUM_SLAVES <= 2) ? 1 : $clog2(NUM_SLAVES);
    localparam int NPAD = 2 ** IDXW;
    localparam int DECW = SLOT_SHIFT + IDXW;
    localparam int CW   = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    logic                  r_slv;
    logic [IDXW-1:0]       r_owner;
    logic [CW-1:0]         r_cnt;
    logic [NUM_SLAVES-1:0] r_quar;
    logic                  r_irq;

    logic                  w_in_range, w_hit, w_accept, w_active, w_expire, w_dflt_start;
    logic [IDXW-1:0]       w_idx;
    logic [NPAD-1:0]       w_quar_pad, w_rdy_pad, w_resp_pad, w_sel_pad, w_own_pad;
    logic [NPAD-1:0][DATA_WIDTH-1:0] w_rdata_pad;
    logic                  w_dflt_rdy, w_dflt_resp;

    assign w_in_range = HADDR_M[ADDR_WIDTH-1:DECW] == BASE_ADDR[ADDR_WIDTH-1:DECW];
    assign w_idx      = HADDR_M[DECW-1:SLOT_SHIFT];

    // Pad per-slot vectors to a power of two so any decoded index is a legal select.
    assign w_quar_pad = NPAD'(r_quar);
    assign w_rdy_pad  = NPAD'(HREADYOUT_S);
    assign w_resp_pad = NPAD'(HRESP_S);

    always_comb begin
        w_rdata_pad = '0;
        for (int i = 0; i < NUM_SLAVES; i++)
            w_rdata_pad[i] = HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign w_hit     = HSEL_M & w_in_range & (32'(w_idx) < NUM_SLAVES) & ~w_quar_pad[w_idx];
    assign w_sel_pad = w_hit ? (NPAD'(1) << w_idx) : '0;
    assign w_own_pad = NPAD'(1) << r_owner;
    assign HSEL_S    = w_sel_pad[NUM_SLAVES-1:0];

    assign HADDR_S  = HADDR_M;
    assign HTRANS_S = HTRANS_M;
    assign HWRITE_S = HWRITE_M;
    assign HSIZE_S  = HSIZE_M;
    assign HBURST_S = HBURST_M;
    assign HPROT_S  = HPROT_M;
    assign HWDATA_S = HWDATA_M;
    assign HREADY_S = HREADY_M;

    assign w_accept     = HREADY_M & HSEL_M;
    assign w_active     = (HTRANS_M == HTRANS_NONSEQ) || (HTRANS_M == HTRANS_SEQ);
    assign w_expire     = (TIMEOUT_CYCLES != 0) && r_slv && !w_rdy_pad[r_owner] && (r_cnt == CNT_LAST);
    assign w_dflt_start = (w_accept & ~w_hit & w_active) | w_expire;

    ahb_default_slave u_dflt (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .i_start     (w_dflt_start),
        .o_hreadyout (w_dflt_rdy),
        .o_hresp     (w_dflt_resp)
    );

    assign HREADYOUT_M = r_slv ? w_rdy_pad[r_owner]   : w_dflt_rdy;
    assign HRESP_M     = r_slv ? w_resp_pad[r_owner]  : w_dflt_resp;
    assign HRDATA_M    = r_slv ? w_rdata_pad[r_owner] : '0;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_slv   <= 1'b0;
            r_owner <= '0;
            r_cnt   <= '0;
            r_quar  <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_irq <= w_expire;
            // A clear pulse wins over an expiry in the same cycle; that set is dropped.
            if (QUAR_CLR)
                r_quar <= '0;
            else if (w_expire)
                r_quar <= r_quar | w_own_pad[NUM_SLAVES-1:0];

            if (w_accept) begin
                r_slv <= w_hit;
                if (w_hit)
                    r_owner <= w_idx;
                r_cnt <= '0;
            end else if (r_slv) begin
                if (w_rdy_pad[r_owner] || w_expire)
                    r_slv <= 1'b0;
                else
                    r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign QUARANTINE  = r_quar;
    assign TIMEOUT_IRQ = r_irq;

endmodule
